// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the pipeline sequencer.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } ctrl_state_e;

  // True when a writing stage targets src; x0 never matches.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic                  wr);
    return wr && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// Combinational EX operand source select; MEM result beats WB result.
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output fwd_sel_e              sel_c
);

  // Pick the youngest in-flight producer of src.
  always_comb begin
    sel_c = FWD_RF;
    if (reg_hit(mem_rd, src, mem_reg_write)) begin
      sel_c = FWD_MEM;
    end else if (reg_hit(wb_rd, src, wb_reg_write)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline sequencer: hazard enables/flushes, forwarding,
// dmem freeze with timeout, and saturating stall/flush statistics.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned STALL_CNT_W    = 32,
  parameter int unsigned FLUSH_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_ADDR_W-1:0]  ex_rs1,
  input  logic [REG_ADDR_W-1:0]  ex_rs2,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_branch_taken,
  input  logic [REG_ADDR_W-1:0]  mem_rd,
  input  logic                   mem_reg_write,
  input  logic [REG_ADDR_W-1:0]  wb_rd,
  input  logic                   wb_reg_write,
  input  logic                   dmem_req,
  input  logic                   dmem_ack,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output fwd_sel_e               fwd_a_sel,
  output fwd_sel_e               fwd_b_sel,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_e       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              dmem_stall;
  logic              load_use;
  logic              branch_flush;
  fwd_sel_e          fwd_a_c;
  fwd_sel_e          fwd_b_c;

  assign dmem_stall = dmem_req & ~dmem_ack;
  assign load_use   = ex_mem_read &
                      (reg_hit(ex_rd, id_rs1, id_uses_rs1) |
                       reg_hit(ex_rd, id_rs2, id_uses_rs2));

  forward_unit u_fwd_a (
    .src           (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel_c         (fwd_a_c)
  );

  forward_unit u_fwd_b (
    .src           (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel_c         (fwd_b_c)
  );

  // Stage enables/flushes: freeze beats branch beats load-use.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    branch_flush = 1'b0;
    fwd_a_sel    = FWD_RF;
    fwd_b_sel    = FWD_RF;
    if (rst_n) begin
      fwd_a_sel = fwd_a_c;
      fwd_b_sel = fwd_b_c;
      if ((state != ERROR) && !dmem_stall) begin
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        if (ex_branch_taken) begin
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          branch_flush = 1'b1;
        end else if (load_use) begin
          id_ex_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
        end
      end
    end
  end

  // Sequencer state, dmem wait timer, sticky timeout and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
      if (branch_flush && (flush_count != '1)) begin
        flush_count <= flush_count + FLUSH_CNT_W'(1);
      end
      case (state)
        RUN, MEM_WAIT: begin
          if (dmem_stall) begin
            if (wait_cnt == WAIT_LAST) begin
              state       <= ERROR;
              mem_timeout <= 1'b1;
            end else begin
              state    <= MEM_WAIT;
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        ERROR: begin
          state       <= ERROR;
          mem_timeout <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed + random bench for pipeline_ctrl against a behavioural model.
module tb_pipeline_ctrl;
  import pipeline_pkg::*;

  localparam int unsigned T  = 8;
  localparam int unsigned SW = 5;
  localparam int unsigned FW = 3;
  localparam int SMAX = (1 << SW) - 1;
  localparam int FMAX = (1 << FW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic          mem_reg_write, wb_reg_write, dmem_req, dmem_ack;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, mem_timeout;
  fwd_sel_e      fwd_a_sel, fwd_b_sel;
  logic [SW-1:0] stall_cycles;
  logic [FW-1:0] flush_count;
  logic [6:0]    ctrl_vec;

  int total = 0;
  int bad   = 0;
  bit m_err;
  int m_wait, m_stall, m_flush;

  pipeline_ctrl #(.TIMEOUT_CYCLES(T), .STALL_CNT_W(SW), .FLUSH_CNT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign ctrl_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {pc,if_id,id_ex,ex_mem,mem_wb,if_id_flush,id_ex_flush}.
  function automatic logic [6:0] exp_ctrl();
    bit stall = dmem_req && !dmem_ack;
    bit lu = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (m_err || stall) return 7'b0000000;
    if (ex_branch_taken) return 7'b1111111;
    if (lu) return 7'b0011101;
    return 7'b1111100;
  endfunction

  function automatic int exp_fwd(input logic [4:0] src);
    if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 1;
    return 0;
  endfunction

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
    mem_reg_write = 0; wb_reg_write = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cycle(input string tag);
    logic [6:0] e;
    #1;
    e = exp_ctrl();
    chk({tag, ":ctrl"}, 32'(ctrl_vec), 32'(e));
    chk({tag, ":fwd_a"}, 32'(fwd_a_sel), 32'(exp_fwd(ex_rs1)));
    chk({tag, ":fwd_b"}, 32'(fwd_b_sel), 32'(exp_fwd(ex_rs2)));
    @(posedge clk);
    if (!e[6]) m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
    if (e[1])  m_flush = (m_flush < FMAX) ? m_flush + 1 : FMAX;
    if (!m_err) begin
      if (dmem_req && !dmem_ack) begin
        if (m_wait + 1 >= int'(T)) m_err = 1'b1;
        else m_wait++;
      end else begin
        m_wait = 0;
      end
    end
    #1;
    chk({tag, ":stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
    chk({tag, ":flush_count"}, 32'(flush_count), 32'(m_flush));
    chk({tag, ":mem_timeout"}, 32'(mem_timeout), 32'(m_err));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ":rst_ctrl"}, 32'(ctrl_vec), 32'd0);
    chk({tag, ":rst_fwd_a"}, 32'(fwd_a_sel), 32'(FWD_RF));
    chk({tag, ":rst_timeout"}, 32'(mem_timeout), 32'd0);
    chk({tag, ":rst_stall"}, 32'(stall_cycles), 32'd0);
    chk({tag, ":rst_flush"}, 32'(flush_count), 32'd0);
    m_err = 1'b0; m_wait = 0; m_stall = 0; m_flush = 0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    // Inputs that would otherwise flush and forward, to prove reset masks them.
    ex_branch_taken = 1; mem_reg_write = 1; mem_rd = 3; ex_rs1 = 3;
    #1;
    pulse_reset("reset");
    idle();
    cycle("idle");

    // Load-use: single stall cycle, bubble clears it.
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    cycle("load_use");
    chk("load_use_stall_count", 32'(stall_cycles), 32'd1);
    ex_mem_read = 0; ex_rd = 0;
    cycle("load_use_bubble");

    // Load into x0 or unused operand never stalls.
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    cycle("load_x0");
    ex_rd = 6; id_rs2 = 6; id_uses_rs2 = 0; id_rs1 = 1;
    cycle("load_unused_rs2");
    idle();

    // Forwarding priority and x0.
    mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 7; ex_rs2 = 0;
    cycle("fwd_prio");
    mem_reg_write = 0; ex_rs2 = 7;
    cycle("fwd_wb");
    mem_rd = 0; wb_rd = 0; mem_reg_write = 1; ex_rs1 = 0; ex_rs2 = 0;
    cycle("fwd_x0");
    idle();

    // Branch together with load-use: branch wins.
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_uses_rs1 = 1;
    cycle("branch_lu");
    chk("branch_lu_flush_count", 32'(flush_count), 32'd1);
    idle();

    // dmem wait of 3 cycles with pending branch; flush only on ack cycle.
    dmem_req = 1; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) cycle("dmem_wait");
    dmem_ack = 1;
    cycle("dmem_ack");
    chk("dmem_ack_flush_count", 32'(flush_count), 32'd2);
    idle();
    dmem_req = 1; dmem_ack = 1;
    cycle("zero_wait");
    idle();
    cycle("after_wait");

    // Timeout after T consecutive wait cycles, sticky until reset.
    dmem_req = 1;
    for (int i = 0; i < int'(T) - 1; i++) cycle("pre_timeout");
    chk("no_timeout_yet", 32'(mem_timeout), 32'd0);
    cycle("timeout_edge");
    chk("timeout_set", 32'(mem_timeout), 32'd1);
    dmem_ack = 1; dmem_req = 0;
    for (int i = 0; i < 3; i++) cycle("error_hold");
    chk("timeout_sticky", 32'(mem_timeout), 32'd1);
    pulse_reset("reset_from_error");
    idle();
    cycle("post_error");

    // Counter saturation.
    ex_mem_read = 1; ex_rd = 4; id_rs2 = 4; id_uses_rs2 = 1;
    for (int i = 0; i < SMAX + 9; i++) cycle("stall_sat");
    chk("stall_saturated", 32'(stall_cycles), 32'(SMAX));
    idle();
    ex_branch_taken = 1;
    for (int i = 0; i < FMAX + 3; i++) cycle("flush_sat");
    chk("flush_saturated", 32'(flush_count), 32'(FMAX));
    pulse_reset("reset_after_sat");
    idle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
      dmem_req = ($urandom_range(0, 2) == 0);
      dmem_ack = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0 && dmem_req) dmem_ack = 0;
      cycle("random");
      if (m_err && $urandom_range(0, 3) == 0) pulse_reset("random_reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the 5-stage RISC-V core. It detects data and control hazards and generates per-stage register enables, flushes and EX-stage operand forwarding selects. It freezes the pipeline while the data memory handshake is outstanding and keeps saturating stall and flush statistics. It sits beside the pipeline registers and drives their enable and flush pins directly.

## Interface
- TIMEOUT_CYCLES, 256: consecutive dmem wait cycles before a fatal timeout.
- STALL_CNT_W, 32: width of the stall cycle counter.
- FLUSH_CNT_W, 16: width of the flush counter.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX.
- ex_rd  in  5  destination register in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_rd  in  5  destination register in MEM.
- mem_reg_write  in  1  MEM instruction writes a register.
- wb_rd  in  5  destination register in WB.
- wb_reg_write  in  1  WB instruction writes a register.
- dmem_req  in  1  MEM stage has an active data memory access.
- dmem_ack  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (NOP, valid=0) at the next edge.
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand source (fwd_sel_e).
- mem_timeout  out  1  sticky fatal error.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_en=0.
- flush_count  out  FLUSH_CNT_W  saturating count of branch flushes.

## Operation
- States: RUN, MEM_WAIT, ERROR. Reset enters RUN.
- dmem_stall = dmem_req & ~dmem_ack.
- In RUN or MEM_WAIT with dmem_stall=1:
  - All five enables are 0 and both flushes are 0.
  - Go to (or stay in) MEM_WAIT.
  - Branch and load-use conditions are ignored this cycle. They are re-evaluated after the freeze.
- MEM_WAIT with dmem_ack=1: normal evaluation this cycle, return to RUN.
- Branch (ex_branch_taken=1, no dmem_stall):
  - All enables 1; if_id_flush=1 and id_ex_flush=1.
  - PC loads the target.
  - flush_count increments.
  - Branch takes priority over load-use.
- Load-use hazard: ex_mem_read & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - pc_en=0, if_id_en=0, id_ex_flush=1; other enables 1.
  - The bubble clears the condition, so the stall lasts exactly 1 cycle.
- Forwarding, per operand (for A, src = ex_rs1):
  - FWD_MEM if mem_reg_write & mem_rd≠0 & mem_rd==src.
  - Otherwise FWD_WB if wb_reg_write & wb_rd≠0 & wb_rd==src.
  - Otherwise FWD_RF. MEM has priority over WB.
- Timeout:
  - wait_cnt counts consecutive dmem_stall cycles and clears when dmem_stall=0.
  - When wait_cnt reaches TIMEOUT_CYCLES-1 with dmem_stall still 1, go to ERROR.
  - ERROR: all enables 0, flushes 0, mem_timeout=1. Only rst_n exits.
- Counters:
  - stall_cycles increments on every cycle with pc_en=0 outside reset, including ERROR.
  - Both counters saturate at all-ones.

## Timing
- Enables, flushes and fwd selects are combinational from the current inputs and state. There is no added latency.
- State, wait_cnt, counters and mem_timeout are registered on the rising clk edge.
- While rst_n=0:
  - All enables 0, flushes 0, fwd selects FWD_RF.
  - mem_timeout 0, counters 0, state RUN.
- Reset assertion mid-wait or in ERROR clears everything asynchronously.
- dmem_req and dmem_ack both 1 in the same cycle: treated as no stall (zero-wait access).
- Register x0 never forwards and never causes a stall.

## Structure
- Package pipeline_pkg holds:
  - fwd_sel_e: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - ctrl_state_e: RUN, MEM_WAIT, ERROR.
  - REG_ADDR_W=5.
- Sub-module forward_unit: purely combinational operand forwarding select. It is instantiated twice, once per operand.
- The FSM, timeout and counters live in pipeline_ctrl.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1 afterwards.
- Forwarding priority: mem_rd=wb_rd=7, both writing, ex_rs1=7, ex_rs2=0 → fwd_a_sel=FWD_MEM, fwd_b_sel=FWD_RF.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with a load-use match → both flushes 1, pc_en=1, flush_count increments by 1.
- dmem wait: dmem_req=1 with ack after 3 cycles → 3 cycles of all enables 0, then normal operation; a concurrent branch flush occurs only on the ack cycle.
- Timeout: TIMEOUT_CYCLES=4, dmem_req=1 with ack never asserted → mem_timeout=1 after 4 cycles and stays 1; async rst_n pulse clears it.
- Saturation: STALL_CNT_W=4 with 20 stall cycles → stall_cycles holds 15.
